cmd_dispatch: RTL and testbench
===============================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue entries, power of two and at least 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  trace command offered.
REQ-005 cmd_ready  out  1  queue accepts; a transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-006 cmd_op  in  4  command code: READ=0, WRITE=1, I_FETCH=2, L2_INVAL=3, L2_DATA_RQ=4, CLR=8, PRINT=9.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 d_req_valid  out  1  data-cache request pending.
REQ-009 d_req_ready  in  1  data cache accepts.
REQ-010 d_req_op  out  4  one of READ, WRITE, L2_INVAL, L2_DATA_RQ.
REQ-011 d_tag / d_index / d_offset  out  12/14/6  cmd_addr[31:20] / [19:6] / [5:0].
REQ-012 i_req_valid  out  1  instruction-cache fetch pending.
REQ-013 i_req_ready  in  1  instruction cache accepts.
REQ-014 i_tag / i_index / i_offset  out  12/14/6  same split as the data-cache fields.
REQ-015 clr_pulse  out  1  one-cycle cache/statistics clear.
REQ-016 print_pulse  out  1  one-cycle dump request.
REQ-017 rd_cnt, wr_cnt, if_cnt, bad_cnt  out  32 each  dispatched READ, WRITE and I_FETCH commands, and dropped illegal codes.

Function
REQ-018 Accepted commands SHALL enter a FIFO_DEPTH-entry in-order queue, storing {op, addr}.
REQ-019 cmd_ready SHALL equal not-full; a pop in the same cycle SHALL NOT make room for a push (no bypass).
REQ-020 FSM states SHALL be IDLE, D_REQ, I_REQ, CLEAR, PRINT.
REQ-021 IDLE with an empty queue SHALL stay in IDLE with all valids and pulses at 0.
REQ-022 IDLE with a non-empty queue SHALL decode the head:
- READ, WRITE, L2_INVAL, L2_DATA_RQ -> D_REQ.
- I_FETCH -> I_REQ.
- CLR -> CLEAR.
- PRINT -> PRINT.
- Any other code -> pop the head, increment bad_cnt, stay in IDLE.
REQ-023 In D_REQ, d_req_valid SHALL be 1 and the payload SHALL be held stable until d_req_ready=1; that cycle pops the head, increments rd_cnt (READ) or wr_cnt (WRITE), and returns to IDLE.
REQ-024 I_REQ SHALL behave like D_REQ on the i_* ports and increment if_cnt.
REQ-025 CLEAR SHALL assert clr_pulse for exactly one cycle, zero rd_cnt, wr_cnt, if_cnt and bad_cnt on that edge, pop the head, and return to IDLE.
REQ-026 PRINT SHALL assert print_pulse for exactly one cycle, pop the head, and return to IDLE; counters are unchanged.
REQ-027 d_req_valid and i_req_valid SHALL never both be 1; at most one command is outstanding.
REQ-028 Latency: an accepted command into an empty idle queue SHALL raise its valid or pulse 2 cycles after the accepting edge.
REQ-029 Counters SHALL wrap from 0xFFFF_FFFF to 0.
REQ-030 The queue pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked in a log2(FIFO_DEPTH)+1-bit count.

Reset
REQ-031 While rst_n=0:
- queue empty; cmd_ready=0.
- FSM in IDLE.
- All valids and pulses 0; all counters 0; address fields 0.
REQ-032 Reset asserted mid-handshake SHALL drop the pending request with no partial count.
REQ-033 cmd_ready SHALL go to 1 on the first edge after rst_n rises.

Structure
REQ-034 The shared package SHALL hold:
- The command enum.
- ADDRESS_BITS, TAG_BITS, INDEX_BITS and OFFSET_BITS.
- A cmd_entry_t struct {op, addr}.
REQ-035 The queue SHALL be a sub-module named cmd_fifo; decode, FSM and counters SHALL live in cmd_dispatch.

Verification
REQ-036 READ at 0x1234_5678 with d_req_ready=1 -> d_req_valid 2 cycles later with d_tag=0x123, d_index=0x1159, d_offset=0x38; rd_cnt=1.
REQ-037 I_FETCH with i_req_ready held 0 for 5 cycles -> i_req_valid and the payload stable for 6 cycles; if_cnt increments only on the handshake.
REQ-038 Push 5 commands back-to-back with both caches stalled -> cmd_ready=0 after the 4th; the 5th is accepted one cycle after the first pop.
REQ-039 Sequence WRITE, WRITE, CLR, READ, op=7 -> clr_pulse once; final wr_cnt=0, rd_cnt=1, bad_cnt=1.
REQ-040 Reset asserted during D_REQ with d_req_ready=0 -> d_req_valid=0 at once; queue empty and counters 0 after release.
REQ-041 PRINT between two READs -> exactly one print_pulse, issued in order between the two d_req handshakes.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
// Shared types and address-split constants for the trace command dispatcher.
package cmd_dispatch_pkg;

  localparam int unsigned ADDRESS_BITS = 32;
  localparam int unsigned TAG_BITS     = 12;
  localparam int unsigned INDEX_BITS   = 14;
  localparam int unsigned OFFSET_BITS  = 6;

  typedef enum logic [3:0] {
    OpRead     = 4'd0,
    OpWrite    = 4'd1,
    OpIFetch   = 4'd2,
    OpL2Inval  = 4'd3,
    OpL2DataRq = 4'd4,
    OpClr      = 4'd8,
    OpPrint    = 4'd9
  } cmd_op_e;

  // op is kept as raw bits so illegal codes survive the queue and can be counted.
  typedef struct packed {
    logic [3:0]              op;
    logic [ADDRESS_BITS-1:0] addr;
  } cmd_entry_t;

  function automatic logic is_dcache_op(logic [3:0] op);
    return op inside {OpRead, OpWrite, OpL2Inval, OpL2DataRq};
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command input, cache request outputs, pulses and statistics of cmd_dispatch.
interface cmd_dispatch_if;
  import cmd_dispatch_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              cmd_op;
  logic [ADDRESS_BITS-1:0] cmd_addr;

  logic                    d_req_valid;
  logic                    d_req_ready;
  logic [3:0]              d_req_op;
  logic [TAG_BITS-1:0]     d_tag;
  logic [INDEX_BITS-1:0]   d_index;
  logic [OFFSET_BITS-1:0]  d_offset;

  logic                    i_req_valid;
  logic                    i_req_ready;
  logic [TAG_BITS-1:0]     i_tag;
  logic [INDEX_BITS-1:0]   i_index;
  logic [OFFSET_BITS-1:0]  i_offset;

  logic                    clr_pulse;
  logic                    print_pulse;
  logic [31:0]             rd_cnt, wr_cnt, if_cnt, bad_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, d_req_ready, i_req_ready,
    input  cmd_ready, d_req_valid, d_req_op, d_tag, d_index, d_offset,
    input  i_req_valid, i_tag, i_index, i_offset, clr_pulse, print_pulse,
    input  rd_cnt, wr_cnt, if_cnt, bad_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, d_req_ready, i_req_ready,
    output cmd_ready, d_req_valid, d_req_op, d_tag, d_index, d_offset,
    output i_req_valid, i_tag, i_index, i_offset, clr_pulse, print_pulse,
    output rd_cnt, wr_cnt, if_cnt, bad_cnt
  );

endinterface

// File: rtl/cmd_fifo.sv
// In-order command queue of {op, addr}; a pop never frees space for a same-cycle push.
module cmd_fifo
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  cmd_entry_t push_data_i,
  input  logic       pop_i,
  output logic       ready_o,
  output logic       empty_o,
  output cmd_entry_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  cmd_entry_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            en_q;
  logic            push_ok, pop_ok;

  // en_q holds ready low until the first edge after reset release.
  assign ready_o = en_q && (count_q != CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && ready_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Decodes queued trace commands and issues them to the data/instruction caches,
// the clear/print pulses and the statistics counters, one command at a time.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  cmd_dispatch_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDReq, StIReq, StClear, StPrint} state_e;

  state_e                  state_q, state_d;
  cmd_entry_t              head;
  logic                    fifo_empty, pop;
  logic                    d_hs, i_hs;
  logic                    d_valid_q, i_valid_q, clr_q, print_q;
  logic [3:0]              d_op_q;
  logic [ADDRESS_BITS-1:0] d_addr_q, i_addr_q;
  logic [31:0]             rd_q, wr_q, if_q, bad_q;
  logic [31:0]             rd_d, wr_d, if_d, bad_d;

  cmd_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (bus.cmd_valid),
    .push_data_i({bus.cmd_op, bus.cmd_addr}),
    .pop_i      (pop),
    .ready_o    (bus.cmd_ready),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  assign d_hs = d_valid_q && bus.d_req_ready;
  assign i_hs = i_valid_q && bus.i_req_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if_d    = if_q;
    bad_d   = bad_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (is_dcache_op(head.op)) begin
            state_d = StDReq;
          end else begin
            unique case (head.op)
              OpIFetch: state_d = StIReq;
              OpClr:    state_d = StClear;
              OpPrint:  state_d = StPrint;
              default: begin
                pop   = 1'b1;
                bad_d = bad_q + 32'd1;
              end
            endcase
          end
        end
      end
      StDReq: begin
        if (d_hs) begin
          pop     = 1'b1;
          state_d = StIdle;
          if (head.op == OpRead)  rd_d = rd_q + 32'd1;
          if (head.op == OpWrite) wr_d = wr_q + 32'd1;
        end
      end
      StIReq: begin
        if (i_hs) begin
          pop     = 1'b1;
          if_d    = if_q + 32'd1;
          state_d = StIdle;
        end
      end
      StClear: begin
        pop     = 1'b1;
        rd_d    = '0;
        wr_d    = '0;
        if_d    = '0;
        bad_d   = '0;
        state_d = StIdle;
      end
      StPrint: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Valids and pulses are registered one cycle behind the state, so a command
  // reaching an empty idle queue shows up two edges after it was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      d_valid_q <= 1'b0;
      i_valid_q <= 1'b0;
      clr_q     <= 1'b0;
      print_q   <= 1'b0;
      d_op_q    <= '0;
      d_addr_q  <= '0;
      i_addr_q  <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      if_q      <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_valid_q <= (state_q == StDReq) && !d_hs;
      i_valid_q <= (state_q == StIReq) && !i_hs;
      clr_q     <= (state_q == StClear);
      print_q   <= (state_q == StPrint);
      if (state_q == StDReq) begin
        d_op_q   <= head.op;
        d_addr_q <= head.addr;
      end
      if (state_q == StIReq) i_addr_q <= head.addr;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      if_q      <= if_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.d_req_valid = d_valid_q;
  assign bus.d_req_op    = d_op_q;
  assign bus.d_tag       = d_addr_q[ADDRESS_BITS-1 -: TAG_BITS];
  assign bus.d_index     = d_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign bus.d_offset    = d_addr_q[OFFSET_BITS-1:0];
  assign bus.i_req_valid = i_valid_q;
  assign bus.i_tag       = i_addr_q[ADDRESS_BITS-1 -: TAG_BITS];
  assign bus.i_index     = i_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign bus.i_offset    = i_addr_q[OFFSET_BITS-1:0];
  assign bus.clr_pulse   = clr_q;
  assign bus.print_pulse = print_q;
  assign bus.rd_cnt      = rd_q;
  assign bus.wr_cnt      = wr_q;
  assign bus.if_cnt      = if_q;
  assign bus.bad_cnt     = bad_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a transaction-level scoreboard checked every cycle.
module tb_cmd_dispatch;
  import cmd_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  cmd_dispatch_if bus ();

  cmd_dispatch #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
  } mcmd_t;

  mcmd_t       mq[$];
  logic [31:0] m_rd, m_wr, m_if, m_bad;
  int          streak = 0;
  int          n_clr = 0;
  int          n_print = 0;
  int          ev[$];
  int          dhs_edges[$];

  function automatic bit legal(logic [3:0] op);
    return (op <= 4'd4) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic bit is_d(logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd3) || (op == 4'd4);
  endfunction

  function automatic logic [31:0] split(logic [31:0] a);
    return {12'(a >> 20), 14'((a >> 6) & 32'h3FFF), 6'(a & 32'h3F)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rd = 0; m_wr = 0; m_if = 0; m_bad = 0;
      streak = 0;
      check("rst_ctl", {59'd0, bus.cmd_ready, bus.d_req_valid, bus.i_req_valid,
                        bus.clr_pulse, bus.print_pulse}, 64'd0);
      check("rst_addr", {bus.d_tag, bus.d_index, bus.d_offset,
                         bus.i_tag, bus.i_index, bus.i_offset}, 64'd0);
      check("rst_cnt_rw", {bus.rd_cnt, bus.wr_cnt}, 64'd0);
      check("rst_cnt_ib", {bus.if_cnt, bus.bad_cnt}, 64'd0);
    end else begin
      while (mq.size() > 0 && !legal(mq[0].op)) begin
        void'(mq.pop_front());
        m_bad++;
      end
      check("valid_excl", {63'd0, bus.d_req_valid && bus.i_req_valid}, 64'd0);
      if (bus.d_req_valid) begin
        check("d_head_present", {63'd0, mq.size() > 0 && is_d(mq[0].op)}, 64'd1);
        if (mq.size() > 0) begin
          check("d_payload", {bus.d_req_op, bus.d_tag, bus.d_index, bus.d_offset},
                {mq[0].op, split(mq[0].addr)});
          if (bus.d_req_ready) begin
            if (mq[0].op == 4'd0) m_rd++;
            if (mq[0].op == 4'd1) m_wr++;
            void'(mq.pop_front());
            ev.push_back(1);
            dhs_edges.push_back(cyc + 1);
          end
        end
      end
      if (bus.i_req_valid) begin
        check("i_head_present", {63'd0, mq.size() > 0 && mq[0].op == 4'd2}, 64'd1);
        if (mq.size() > 0) begin
          check("i_payload", {bus.i_tag, bus.i_index, bus.i_offset}, split(mq[0].addr));
          if (bus.i_req_ready) begin
            m_if++;
            void'(mq.pop_front());
          end
        end
      end
      if (bus.clr_pulse) begin
        n_clr++;
        check("clr_head", {63'd0, mq.size() > 0 && mq[0].op == 4'd8}, 64'd1);
        if (mq.size() > 0) void'(mq.pop_front());
        m_rd = 0; m_wr = 0; m_if = 0; m_bad = 0;
      end
      if (bus.print_pulse) begin
        n_print++;
        ev.push_back(2);
        check("print_head", {63'd0, mq.size() > 0 && mq[0].op == 4'd9}, 64'd1);
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (bus.cmd_valid && bus.cmd_ready) mq.push_back('{bus.cmd_op, bus.cmd_addr});
      if (mq.size() == 0 && !bus.d_req_valid && !bus.i_req_valid && !bus.clr_pulse &&
          !bus.print_pulse) streak++;
      else streak = 0;
      // Counters only settle once the queue has stayed drained for a few cycles.
      if (streak >= 3) begin
        check("cnt_rw", {bus.rd_cnt, bus.wr_cnt}, {m_rd, m_wr});
        check("cnt_ib", {bus.if_cnt, bus.bad_cnt}, {m_if, m_bad});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] addr, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    bus.cmd_op = op;
    bus.cmd_addr = addr;
    bus.cmd_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #2;
    end
    bus.cmd_valid = 1'b0;
    if (ok) acc = cyc;
    else check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input bit inst, output int lat);
    lat = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((inst ? bus.i_req_valid : bus.d_req_valid) === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc, acc1, acc4, lat, n_hi, clr0, pr0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.d_req_ready = 1'b1;
    bus.i_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready_before_edge", {63'd0, bus.cmd_ready}, 64'd0);
    @(posedge clk);
    #1 check("ready_after_edge", {63'd0, bus.cmd_ready}, 64'd1);
    #1;

    // READ 0x1234_5678: valid two edges after acceptance, fixed field split
    send(OpRead, 32'h1234_5678, acc);
    wait_valid(1'b0, lat);
    check("read_latency", 64'(lat), 64'd2);
    check("read_fields", {bus.d_req_op, bus.d_tag, bus.d_index, bus.d_offset},
          {4'h0, 12'h123, 14'h1159, 6'h38});
    @(negedge clk);
    check("rd_cnt_first", 64'(bus.rd_cnt), 64'd1);
    check("d_valid_dropped", {63'd0, bus.d_req_valid}, 64'd0);
    step(1);

    // I_FETCH stalled for 5 cycles
    bus.i_req_ready = 1'b0;
    send(OpIFetch, 32'hABCD_EF40, acc);
    wait_valid(1'b1, lat);
    n_hi = 1;
    check("ifetch_fields", {bus.i_tag, bus.i_index, bus.i_offset}, {12'hABC, 14'h37BD, 6'h00});
    repeat (4) begin
      @(negedge clk);
      if (bus.i_req_valid) n_hi++;
    end
    @(posedge clk);
    #2 bus.i_req_ready = 1'b1;
    @(negedge clk);
    if (bus.i_req_valid) n_hi++;
    check("if_cnt_before_hs", 64'(bus.if_cnt), 64'd0);
    @(negedge clk);
    check("i_valid_cycles", 64'(n_hi), 64'd6);
    check("i_valid_dropped", {63'd0, bus.i_req_valid}, 64'd0);
    check("if_cnt_after_hs", 64'(bus.if_cnt), 64'd1);
    step(1);

    // Fill the queue with both caches stalled
    bus.d_req_ready = 1'b0;
    bus.i_req_ready = 1'b0;
    send(OpRead, 32'h0000_0100, acc1);
    send(OpRead, 32'h0000_0200, acc);
    send(OpRead, 32'h0000_0300, acc);
    send(OpRead, 32'h0000_0400, acc4);
    check("fill_back_to_back", 64'(acc4 - acc1), 64'd3);
    @(negedge clk);
    check("full_not_ready", {63'd0, bus.cmd_ready}, 64'd0);
    step(1);
    bus.cmd_op = OpRead;
    bus.cmd_addr = 32'h0000_0500;
    bus.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_held", {63'd0, bus.cmd_ready}, 64'd0);
      step(1);
    end
    dhs_edges.delete();
    bus.d_req_ready = 1'b1;
    bus.i_req_ready = 1'b1;
    send(OpRead, 32'h0000_0500, acc);
    if (dhs_edges.size() > 0) check("fifth_after_pop", 64'(acc), 64'(dhs_edges[0] + 1));
    else check("first_pop_seen", 64'd0, 64'd1);
    step(40);
    check("rd_cnt_after_fill", 64'(bus.rd_cnt), 64'd6);

    // L2 traffic plus an illegal code
    send(OpL2Inval, 32'hDEAD_BEEF, acc);
    send(OpL2DataRq, 32'h0000_0FC0, acc);
    send(4'd12, 32'h0, acc);
    step(30);
    check("bad_cnt_12", 64'(bus.bad_cnt), 64'd1);
    check("rd_cnt_l2", 64'(bus.rd_cnt), 64'd6);

    // WRITE, WRITE, CLR, READ, op=7
    clr0 = n_clr;
    send(OpWrite, 32'h0000_1000, acc);
    send(OpWrite, 32'h0000_2000, acc);
    send(OpClr, 32'h0, acc);
    send(OpRead, 32'h0000_3000, acc);
    send(4'd7, 32'h0, acc);
    step(40);
    check("clr_once", 64'(n_clr - clr0), 64'd1);
    check("seq_wr", 64'(bus.wr_cnt), 64'd0);
    check("seq_rd", 64'(bus.rd_cnt), 64'd1);
    check("seq_bad", 64'(bus.bad_cnt), 64'd1);
    check("seq_if", 64'(bus.if_cnt), 64'd0);

    // PRINT between two READs
    pr0 = n_print;
    ev.delete();
    send(OpRead, 32'h0000_4000, acc);
    send(OpPrint, 32'h0, acc);
    send(OpRead, 32'h0000_5000, acc);
    step(30);
    check("print_once", 64'(n_print - pr0), 64'd1);
    if (ev.size() == 3) check("print_order", 64'(ev[0] * 100 + ev[1] * 10 + ev[2]), 64'd121);
    else check("event_count", 64'(ev.size()), 64'd3);
    check("rd_after_print", 64'(bus.rd_cnt), 64'd3);

    // Reset during a stalled D_REQ
    bus.d_req_ready = 1'b0;
    send(OpRead, 32'h0000_7770, acc);
    wait_valid(1'b0, lat);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_drops_valid", {63'd0, bus.d_req_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.d_req_ready = 1'b1;
    step(2);
    check("post_rst_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("post_rst_rd", 64'(bus.rd_cnt), 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("post_rst_empty", {63'd0, bus.d_req_valid}, 64'd0);
    end
    step(1);
    send(OpRead, 32'h1234_5678, acc);
    step(10);
    check("rd_after_rst", 64'(bus.rd_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
